move_queue: RTL and testbench

//  Buffers solver move bursts and dispatches them one at a time to move_to_step.

---
 rtl/rbot_pkg.sv | 42 ++++
 rtl/move_fifo.sv | 67 ++++++
 rtl/move_queue.sv | 249 ++++++++++++++++++++++++
 tb/tb_move_queue.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbot_pkg.sv
// -----------------------------------------------------------------------------
// rbot_pkg
//   Shared definitions for the move dispatch path: move code width, the move
//   code set produced by the solver, the dispatcher state encoding and a
//   helper that tells a real move code from filler nibbles.
//   Build option: MOVE_SETTLE_EN (used by move_queue) enables the SETTLE state.
// -----------------------------------------------------------------------------
package rbot_pkg;

  localparam int MOVE_W = 4;

  // Codes 0 and 1 are padding inside a burst; 2..13 are face turns.
  typedef enum logic [MOVE_W-1:0] {
    MOVE_NONE = 4'd0,
    MOVE_NOP  = 4'd1,
    MOVE_R    = 4'd2,
    MOVE_RI   = 4'd3,
    MOVE_L    = 4'd4,
    MOVE_LI   = 4'd5,
    MOVE_U    = 4'd6,
    MOVE_UI   = 4'd7,
    MOVE_F    = 4'd8,
    MOVE_FI   = 4'd9,
    MOVE_B    = 4'd10,
    MOVE_BI   = 4'd11,
    MOVE_D    = 4'd12,
    MOVE_DI   = 4'd13
  } move_t;

  // Dispatcher state encoding (exposed on move_queue.dbg_state).
  localparam int         ST_W      = 3;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic is_move(input logic [MOVE_W-1:0] nib);
    return (nib >= MOVE_R) && (nib <= MOVE_DI);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// -----------------------------------------------------------------------------
// move_fifo
//   Synchronous FIFO of DEPTH move codes. Head is read combinationally.
//   A push while full is accepted only when a pop happens on the same cycle.
//   Pointers carry one extra wrap bit to separate full from empty.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        synchronous clear (empties the FIFO, wins over push/pop)
//   i_push       write i_data
//   i_pop        drop the head entry
//   i_data       move code to write
//   o_head       oldest entry
//   o_full       DEPTH entries stored
//   o_empty      no entries stored
// -----------------------------------------------------------------------------
module move_fifo
  import rbot_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [MOVE_W-1:0] i_data,
  output logic [MOVE_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [MOVE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/move_queue.sv
// -----------------------------------------------------------------------------
// move_queue
//   Buffers solver move bursts and hands them one at a time to move_to_step.
//   A burst is unpacked MSB nibble first, one nibble per cycle, into a FIFO
//   (padding codes 0/1 skipped). Once seq_complete has set the go flag the
//   dispatcher issues each move with a one-cycle move_start and waits for a
//   rising edge of move_done. When everything enqueued has completed and no
//   burst is being unpacked, seq_done pulses once and go clears.
//
//   Handshake (move_to_step): move_start is high for exactly one cycle while
//   next_move already holds the code; next_move stays stable until the next
//   issue. Completion is a 0->1 transition of move_done seen while waiting; a
//   level that was already high when the move was issued does not count.
//
// Build option
//   MOVE_SETTLE_EN : adds SETTLE state, an idle gap of SETTLE_CYCLES after
//                    each completed move, and the SETTLE_CYCLES parameter.
// Ports
//   clock, reset_n   25 MHz clock, asynchronous active-low reset
//   moves_in         packed burst (4*BURST_MOVES bits)
//   moves_valid      1-cycle pulse, latch moves_in
//   seq_complete     1-cycle pulse, planning finished
//   flush            synchronous clear of queue, counters, go, overflow
//   next_move        move code to the stepper
//   move_start       1-cycle issue pulse
//   move_done        completion level from move_to_step
//   num_moves        moves enqueued since reset/flush (saturating)
//   curr_step        moves completed since reset/flush (saturating)
//   seq_done         1-cycle pulse, all enqueued moves completed
//   overflow         sticky, a move or a burst was dropped
//   dbg_state        dispatcher state
// -----------------------------------------------------------------------------
module move_queue
  import rbot_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int BURST_MOVES = 50
`ifdef MOVE_SETTLE_EN
  ,
  parameter int SETTLE_CYCLES = 250000
`endif
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [4*BURST_MOVES-1:0] moves_in,
  input  logic                     moves_valid,
  input  logic                     seq_complete,
  input  logic                     flush,
  output logic [MOVE_W-1:0]        next_move,
  output logic                     move_start,
  input  logic                     move_done,
  output logic [7:0]               num_moves,
  output logic [7:0]               curr_step,
  output logic                     seq_done,
  output logic                     overflow,
  output logic [ST_W-1:0]          dbg_state
);

  localparam int BW    = 4 * BURST_MOVES;
  localparam int NIB_W = (BURST_MOVES > 1) ? $clog2(BURST_MOVES) : 1;

  // Unpacker
  logic [BW-1:0]       r_shift;
  logic                r_unpacking;
  logic [NIB_W-1:0]    r_nib_cnt;

  // Control / dispatcher
  logic                r_go;
  logic [ST_W-1:0]     r_state;
  logic [MOVE_W-1:0]   r_next_move;
  logic [7:0]          r_num_moves;
  logic [7:0]          r_curr_step;
  logic                r_overflow;
  logic                r_done_d;

  logic [MOVE_W-1:0]   w_nibble;
  logic [MOVE_W-1:0]   w_head;
  logic                w_push;
  logic                w_push_ok;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_done_rise;

  assign w_nibble    = r_shift[BW-1 -: MOVE_W];
  assign w_push      = r_unpacking && is_move(w_nibble);
  assign w_pop       = (r_state == ST_ISSUE);
  // Mirrors the FIFO's own acceptance rule so drops can be flagged here.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_done_rise = move_done && !r_done_d;

  move_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_nibble),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ---------------------------------------------------------------------------
  // Unpacker: one nibble per cycle, BURST_MOVES cycles per burst.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_unpacking <= 1'b0;
      r_nib_cnt   <= '0;
    end else if (flush) begin
      r_shift     <= '0;
      r_unpacking <= 1'b0;
      r_nib_cnt   <= '0;
    end else if (r_unpacking) begin
      r_shift   <= r_shift << MOVE_W;
      r_nib_cnt <= r_nib_cnt + NIB_W'(1);
      if (r_nib_cnt == NIB_W'(BURST_MOVES - 1)) begin
        r_unpacking <= 1'b0;
      end
    end else if (moves_valid) begin
      r_shift     <= moves_in;
      r_unpacking <= 1'b1;
      r_nib_cnt   <= '0;
    end
  end

  // Overflow and enqueue counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_num_moves <= '0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_num_moves <= '0;
    end else begin
      if ((moves_valid && r_unpacking) || (w_push && !w_push_ok)) begin
        r_overflow <= 1'b1;
      end
      if (w_push_ok && (r_num_moves != 8'hFF)) begin
        r_num_moves <= r_num_moves + 8'd1;
      end
    end
  end

  // go flag: DONE clears it, so a seq_complete landing on DONE is ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_go <= 1'b0;
    end else if (flush) begin
      r_go <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_go <= 1'b0;
    end else if (seq_complete) begin
      r_go <= 1'b1;
    end
  end

  // move_done history for edge detection, free running.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_done_d <= 1'b0;
    end else begin
      r_done_d <= move_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatcher FSM
  // ---------------------------------------------------------------------------
`ifdef MOVE_SETTLE_EN
  localparam int SET_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  logic [SET_W-1:0] r_settle_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_settle_cnt <= '0;
    end else if (flush) begin
      r_settle_cnt <= '0;
    end else if ((r_state == ST_WAIT) && w_done_rise) begin
      r_settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
    end else if ((r_state == ST_SETTLE) && (r_settle_cnt != '0)) begin
      r_settle_cnt <= r_settle_cnt - SET_W'(1);
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_next_move <= MOVE_NONE;
      r_curr_step <= '0;
    end else if (flush) begin
      // Abandon any in-flight move without waiting for move_done.
      r_state     <= ST_IDLE;
      r_next_move <= MOVE_NONE;
      r_curr_step <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // next_move is loaded on entry to ISSUE so it is already valid
          // during the move_start cycle.
          if (r_go && !w_empty) begin
            r_state     <= ST_ISSUE;
            r_next_move <= w_head;
          end else if (r_go && w_empty && !r_unpacking) begin
            r_state <= ST_DONE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done_rise) begin
            if (r_curr_step != 8'hFF) r_curr_step <= r_curr_step + 8'd1;
`ifdef MOVE_SETTLE_EN
            r_state <= ST_SETTLE;
`else
            r_state <= ST_IDLE;
`endif
          end
        end
`ifdef MOVE_SETTLE_EN
        ST_SETTLE: begin
          if (r_settle_cnt == '0) r_state <= ST_IDLE;
        end
`endif
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign next_move  = r_next_move;
  assign move_start = (r_state == ST_ISSUE);
  assign seq_done   = (r_state == ST_DONE);
  assign num_moves  = r_num_moves;
  assign curr_step  = r_curr_step;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_move_queue.sv
// -----------------------------------------------------------------------------
// tb_move_queue
//   Self-checking bench for move_queue. Bursts are generated randomly; the
//   expected move order is derived from the burst contents (codes 2..13 in
//   MSB-first order, truncated at FIFO capacity when nothing is dispatched).
//   A responder task plays move_to_step with random reaction times.
//   Build option MOVE_SETTLE_EN is honoured (SETTLE_CYCLES = 10).
// -----------------------------------------------------------------------------
module tb_move_queue;

  localparam int DEPTH        = 64;
  localparam int BURST_MOVES  = 50;
  localparam int BW           = 4 * BURST_MOVES;
  localparam int SERVE_BUDGET = 3000;
`ifdef MOVE_SETTLE_EN
  localparam int SETTLE       = 10;
  localparam int EXP_GAP      = 2 + SETTLE;
`else
  localparam int EXP_GAP      = 2;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clock = 1'b0;
  logic          reset_n;
  logic [BW-1:0] moves_in;
  logic          moves_valid;
  logic          seq_complete;
  logic          flush;
  logic [3:0]    next_move;
  logic          move_start;
  logic          move_done;
  logic [7:0]    num_moves;
  logic [7:0]    curr_step;
  logic          seq_done;
  logic          overflow;
  logic [2:0]    dbg_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  move_queue #(
    .DEPTH         (DEPTH),
    .BURST_MOVES   (BURST_MOVES)
`ifdef MOVE_SETTLE_EN
    ,
    .SETTLE_CYCLES (SETTLE)
`endif
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .moves_in     (moves_in),
    .moves_valid  (moves_valid),
    .seq_complete (seq_complete),
    .flush        (flush),
    .next_move    (next_move),
    .move_start   (move_start),
    .move_done    (move_done),
    .num_moves    (num_moves),
    .curr_step    (curr_step),
    .seq_done     (seq_done),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int         start_at[$];
  int         rise_at[$];
  int         sc_at;
  int         n_cmp = 0;
  int         n_err = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  // Random burst holding n_mv real moves scattered among 0/1 padding; the
  // real moves are appended to exp_q in dispatch (MSB-first) order.
  task automatic build_burst(input int n_mv, output logic [BW-1:0] b);
    int left;
    logic [3:0] nib;
    left = n_mv;
    b = '0;
    for (int i = BURST_MOVES - 1; i >= 0; i--) begin
      if ($urandom_range(0, i) < left) begin
        nib = 4'($urandom_range(2, 13));
        exp_q.push_back(nib);
        left--;
      end else begin
        nib = 4'($urandom_range(0, 1));
      end
      b[i*4 +: 4] = nib;
    end
  endtask

  task automatic send_burst(input logic [BW-1:0] b);
    @(negedge clock);
    moves_in    = b;
    moves_valid = 1'b1;
    @(negedge clock);
    moves_valid = 1'b0;
  endtask

  task automatic wait_unpack();
    repeat (BURST_MOVES + 3) @(negedge clock);
  endtask

  task automatic pulse_seq_complete();
    @(negedge clock);
    seq_complete = 1'b1;
    sc_at        = cyc;
    @(negedge clock);
    seq_complete = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  // Plays move_to_step: after each move_start, raise move_done after 1..4
  // cycles and hold it 1..3 cycles. Returns after seq_done (plus a short
  // tail), after the stop_after-th start (if nonzero), or on budget expiry.
  task automatic serve_moves(input int stop_after, output int starts,
                             output int dones, output bit timed_out);
    int phase;
    int wait_n;
    int tail;
    got_q.delete();
    start_at.delete();
    rise_at.delete();
    starts = 0; dones = 0; timed_out = 1'b1;
    phase = 0; wait_n = 0; tail = -1;
    for (int c = 0; c < SERVE_BUDGET; c++) begin
      @(negedge clock);
      if (seq_done) begin
        dones++;
        if (tail < 0) tail = 4;
      end
      if (move_start) begin
        starts++;
        got_q.push_back(next_move);
        start_at.push_back(cyc);
        move_done = 1'b0;
        phase     = 1;
        wait_n    = $urandom_range(1, 4);
        if (stop_after > 0 && starts == stop_after) begin
          timed_out = 1'b0;
          break;
        end
      end else if (phase == 1) begin
        wait_n--;
        if (wait_n == 0) begin
          move_done = 1'b1;
          rise_at.push_back(cyc);
          phase     = 2;
          wait_n    = $urandom_range(1, 3);
        end
      end else if (phase == 2) begin
        wait_n--;
        if (wait_n == 0) begin
          move_done = 1'b0;
          phase     = 0;
        end
      end
      if (tail == 0) begin
        timed_out = 1'b0;
        break;
      end
      if (tail > 0) tail--;
    end
    move_done = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    moves_in = '0; moves_valid = 1'b0; seq_complete = 1'b0;
    flush = 1'b0; move_done = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (next_move !== 4'd0) begin n_err++; $display("FAIL reset_next_move: got %0d want 0", next_move); end
    n_cmp++; if (move_start !== 1'b0) begin n_err++; $display("FAIL reset_move_start: got %0b want 0", move_start); end
    n_cmp++; if (num_moves !== 8'd0) begin n_err++; $display("FAIL reset_num_moves: got %0d want 0", num_moves); end
    n_cmp++; if (curr_step !== 8'd0) begin n_err++; $display("FAIL reset_curr_step: got %0d want 0", curr_step); end
    n_cmp++; if (seq_done !== 1'b0) begin n_err++; $display("FAIL reset_seq_done: got %0b want 0", seq_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (move_start !== 1'b0 || seq_done !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset: start=%0b done=%0b want 0/0", move_start, seq_done);
    end
  endtask

  // Burst {R,Ri} right-justified: moves 2 then 3, latency from seq_complete.
  task automatic test_basic();
    int st, dn; bit to;
    exp_q.delete();
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd3);
    send_burst(BW'(8'h23));
    wait_unpack();
    pulse_seq_complete();
    serve_moves(0, st, dn, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL basic_timeout: no seq_done within budget"); end
    n_cmp++; if (st !== 2) begin n_err++; $display("FAIL basic_starts: got %0d want 2", st); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_move%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    if (start_at.size() > 0) begin
      n_cmp++; if (start_at[0] - sc_at !== 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", start_at[0] - sc_at); end
    end
    n_cmp++; if (curr_step !== 8'd2) begin n_err++; $display("FAIL basic_curr_step: got %0d want 2", curr_step); end
    n_cmp++; if (dn !== 1) begin n_err++; $display("FAIL basic_seq_done_count: got %0d want 1", dn); end
    n_cmp++; if (num_moves !== 8'd2) begin n_err++; $display("FAIL basic_num_moves: got %0d want 2", num_moves); end
  endtask

  // Padding nibbles 0/1 around a single move 4.
  task automatic test_filter();
    int st, dn; bit to;
    do_flush();
    send_burst(BW'(32'h0104_1010));
    wait_unpack();
    pulse_seq_complete();
    serve_moves(0, st, dn, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL filter_timeout: no seq_done within budget"); end
    n_cmp++; if (st !== 1) begin n_err++; $display("FAIL filter_starts: got %0d want 1", st); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] !== 4'd4) begin n_err++; $display("FAIL filter_move: got %0d want 4", got_q[0]); end
    end
    n_cmp++; if (num_moves !== 8'd1) begin n_err++; $display("FAIL filter_num_moves: got %0d want 1", num_moves); end
    n_cmp++; if (curr_step !== 8'd1) begin n_err++; $display("FAIL filter_curr_step: got %0d want 1", curr_step); end
  endtask

  // Random bursts fully queued before go; order, counts and move-to-move gap.
  task automatic test_random();
    int st, dn; bit to;
    logic [BW-1:0] b;
    do_flush();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      build_burst($urandom_range(3, 15), b);
      send_burst(b);
      wait_unpack();
    end
    pulse_seq_complete();
    serve_moves(0, st, dn, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL random_timeout: no seq_done within budget"); end
    n_cmp++; if (st !== exp_q.size()) begin n_err++; $display("FAIL random_starts: got %0d want %0d", st, exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL random_move%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    for (int i = 0; i + 1 < start_at.size() && i < rise_at.size(); i++) begin
      n_cmp++; if (start_at[i+1] - rise_at[i] !== EXP_GAP) begin
        n_err++; $display("FAIL random_gap%0d: got %0d want %0d", i, start_at[i+1] - rise_at[i], EXP_GAP);
      end
    end
    n_cmp++; if (num_moves !== 8'(exp_q.size())) begin n_err++; $display("FAIL random_num_moves: got %0d want %0d", num_moves, exp_q.size()); end
    n_cmp++; if (curr_step !== 8'(exp_q.size())) begin n_err++; $display("FAIL random_curr_step: got %0d want %0d", curr_step, exp_q.size()); end
    n_cmp++; if (dn !== 1) begin n_err++; $display("FAIL random_seq_done_count: got %0d want 1", dn); end
  endtask

  // A second burst arrives after go; seq_done must wait for its moves.
  task automatic test_late_burst();
    int st, dn; bit to;
    logic [BW-1:0] b1, b2;
    do_flush();
    exp_q.delete();
    build_burst(4, b1);
    build_burst(6, b2);
    send_burst(b1);
    wait_unpack();
    pulse_seq_complete();
    fork
      serve_moves(0, st, dn, to);
      begin
        repeat (3) @(negedge clock);
        send_burst(b2);
      end
    join
    n_cmp++; if (to) begin n_err++; $display("FAIL late_timeout: no seq_done within budget"); end
    n_cmp++; if (st !== 10) begin n_err++; $display("FAIL late_starts: got %0d want 10", st); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL late_move%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (dn !== 1) begin n_err++; $display("FAIL late_seq_done_count: got %0d want 1", dn); end
  endtask

  // Two 40-move bursts without go: 64 kept, rest dropped; then a burst
  // arriving while another is unpacking is dropped.
  task automatic test_overflow();
    int st, dn; bit to;
    logic [BW-1:0] b1, b2;
    do_flush();
    exp_q.delete();
    build_burst(40, b1);
    build_burst(40, b2);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    send_burst(b1);
    wait_unpack();
    send_burst(b2);
    wait_unpack();
    n_cmp++; if (num_moves !== 8'd64) begin n_err++; $display("FAIL ovf_num_moves: got %0d want 64", num_moves); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    pulse_seq_complete();
    serve_moves(0, st, dn, to);
    n_cmp++; if (st !== DEPTH) begin n_err++; $display("FAIL ovf_starts: got %0d want %0d", st, DEPTH); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_move%0d: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (curr_step !== 8'd64) begin n_err++; $display("FAIL ovf_curr_step: got %0d want 64", curr_step); end

    do_flush();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_flush_clears: got %0b want 0", overflow); end
    exp_q.delete();
    build_burst(5, b1);
    build_burst(7, b2);
    send_burst(b1);
    repeat (3) @(negedge clock);
    send_burst(b2);
    wait_unpack();
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_flag: got %0b want 1", overflow); end
    n_cmp++; if (num_moves !== 8'd5) begin n_err++; $display("FAIL drop_num_moves: got %0d want 5", num_moves); end
    do_flush();
  endtask

  // move_done already high at issue must not complete the move.
  task automatic test_done_held();
    logic [BW-1:0] b;
    bit seen;
    do_flush();
    exp_q.delete();
    @(negedge clock);
    move_done = 1'b1;
    build_burst(1, b);
    send_burst(b);
    wait_unpack();
    pulse_seq_complete();
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (move_start) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL held_start: no move_start within 10 cycles"); end
    n_cmp++; if (next_move !== exp_q[0]) begin n_err++; $display("FAIL held_move: got %0d want %0d", next_move, exp_q[0]); end
    repeat (3) @(negedge clock);
    n_cmp++; if (curr_step !== 8'd0) begin n_err++; $display("FAIL held_high_ignored: got %0d want 0", curr_step); end
    move_done = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (curr_step !== 8'd0) begin n_err++; $display("FAIL held_low: got %0d want 0", curr_step); end
    move_done = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (seq_done) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL held_seq_done: no seq_done within 40 cycles"); end
    n_cmp++; if (curr_step !== 8'd1) begin n_err++; $display("FAIL held_second_rise: got %0d want 1", curr_step); end
    move_done = 1'b0;
  endtask

  // flush while waiting on move 3 of 5 abandons everything.
  task automatic test_flush();
    int st, dn, starts_after, dones_after; bit to;
    logic [BW-1:0] b;
    do_flush();
    exp_q.delete();
    build_burst(5, b);
    send_burst(b);
    wait_unpack();
    pulse_seq_complete();
    serve_moves(3, st, dn, to);
    n_cmp++; if (to || st !== 3) begin n_err++; $display("FAIL flush_reach_move3: starts %0d want 3", st); end
    n_cmp++; if (curr_step !== 8'd2) begin n_err++; $display("FAIL flush_pre_curr_step: got %0d want 2", curr_step); end
    do_flush();
    starts_after = 0; dones_after = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (move_start) starts_after++;
      if (seq_done) dones_after++;
    end
    n_cmp++; if (starts_after !== 0) begin n_err++; $display("FAIL flush_no_start: got %0d want 0", starts_after); end
    n_cmp++; if (dones_after !== 0) begin n_err++; $display("FAIL flush_no_seq_done: got %0d want 0", dones_after); end
    n_cmp++; if (num_moves !== 8'd0) begin n_err++; $display("FAIL flush_num_moves: got %0d want 0", num_moves); end
    n_cmp++; if (curr_step !== 8'd0) begin n_err++; $display("FAIL flush_curr_step: got %0d want 0", curr_step); end
    n_cmp++; if (next_move !== 4'd0) begin n_err++; $display("FAIL flush_next_move: got %0d want 0", next_move); end
  endtask

  // Six rounds of 50 moves without flush: both counters stop at 255.
  task automatic test_saturation();
    int st, dn, total, bad; bit to;
    logic [BW-1:0] b;
    do_flush();
    total = 0;
    for (int r = 0; r < 6; r++) begin
      exp_q.delete();
      build_burst(BURST_MOVES, b);
      send_burst(b);
      wait_unpack();
      pulse_seq_complete();
      serve_moves(0, st, dn, to);
      total += BURST_MOVES;
      bad = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      n_cmp++; if (got_q.size() !== exp_q.size() || bad !== 0) begin
        n_err++; $display("FAIL sat_round%0d: issued %0d (%0d wrong) want %0d in order", r, got_q.size(), bad, exp_q.size());
      end
      n_cmp++; if (num_moves !== 8'((total > 255) ? 255 : total)) begin
        n_err++; $display("FAIL sat_num_moves_r%0d: got %0d want %0d", r, num_moves, (total > 255) ? 255 : total);
      end
    end
    n_cmp++; if (curr_step !== 8'd255) begin n_err++; $display("FAIL sat_curr_step: got %0d want 255", curr_step); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_random();
    test_late_burst();
    test_overflow();
    test_done_held();
    test_flush();
    test_saturation();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
